// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings plus funct3 decode helpers for the
// iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

   // True for the four divide/remainder ops
   function automatic logic is_div(input muldiv_op_t op_i);
      return (op_i == OP_DIV) || (op_i == OP_DIVU) ||
             (op_i == OP_REM) || (op_i == OP_REMU);
   endfunction

   // True for the remainder ops (result taken from the high half)
   function automatic logic is_rem(input muldiv_op_t op_i);
      return (op_i == OP_REM) || (op_i == OP_REMU);
   endfunction

   // rs1 is interpreted as two's complement
   function automatic logic is_signed_a(input muldiv_op_t op_i);
      return (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
             (op_i == OP_DIV)  || (op_i == OP_REM);
   endfunction

   // rs2 is interpreted as two's complement
   function automatic logic is_signed_b(input muldiv_op_t op_i);
      return (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration on the 2*XLEN accumulator.
// Multiply: accumulator is {partial_hi, multiplier}; add the multiplicand
// when the multiplier LSB is set, then shift right by one.
// Divide: accumulator is {remainder, dividend/quotient}; shift left by one
// and keep the trial subtraction when it does not borrow.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic                i_is_div,
   input  logic [2*XLEN-1:0]   i_acc,
   input  logic [XLEN-1:0]     i_opnd,
   output logic [2*XLEN-1:0]   o_acc
);

   logic [XLEN:0] w_sum;
   logic [XLEN:0] w_rem_sh;
   logic [XLEN:0] w_diff;

   // Single iteration: add-or-pass for multiply, trial-subtract for divide
   always_comb begin
      w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd};
      w_rem_sh = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
      w_diff   = w_rem_sh - {1'b0, i_opnd};
      o_acc    = i_acc;
      if (i_is_div) begin
         // Remainder stays below the divisor, so bit XLEN of the
         // difference is a clean borrow flag.
         if (w_diff[XLEN]) begin
            o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
         end else begin
            o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
         end
      end else begin
         if (i_acc[0]) begin
            o_acc = {w_sum, i_acc[XLEN-1:1]};
         end else begin
            o_acc = {1'b0, i_acc[2*XLEN-1:1]};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative M-extension multiply/divide unit. Operands are
// reduced to magnitudes on accept, UNROLL radix-2 steps run per CALC cycle,
// and the sign is restored in FIX. Divide-by-zero and signed overflow skip
// CALC and go straight to DONE.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int N  = XLEN / UNROLL;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] ALL1     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t     r_state;
   muldiv_op_t        r_op;
   logic              r_neg_a;
   logic              r_neg_b;
   logic [XLEN-1:0]   r_opnd;
   logic [2*XLEN-1:0] r_acc;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_result;
   logic              r_out_valid;

   muldiv_op_t        w_op;
   logic              w_neg_a;
   logic              w_neg_b;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic              w_div0;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_spec_res;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fix_res;
   logic              w_is_div_r;
   logic [2*XLEN-1:0] w_chain [0:UNROLL];

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign result    = r_result;

   // Decode the incoming request: signs, magnitudes and special-case divides
   always_comb begin
      w_op    = muldiv_op_t'(op);
      w_neg_a = is_signed_a(w_op) && a[XLEN-1];
      w_neg_b = is_signed_b(w_op) && b[XLEN-1];
      w_mag_a = w_neg_a ? (-a) : a;
      w_mag_b = w_neg_b ? (-b) : b;
      w_div0  = (b == ZERO);
      w_ovf   = is_signed_b(w_op) && (a == MOST_NEG) && (b == ALL1);
      w_special = is_div(w_op) && (w_div0 || w_ovf);
      if (w_div0) begin
         w_spec_res = is_rem(w_op) ? a : ALL1;
      end else begin
         w_spec_res = is_rem(w_op) ? ZERO : a;
      end
   end

   // Sign correction and half selection applied in FIX
   always_comb begin
      w_prod = (r_neg_a ^ r_neg_b) ? (-r_acc) : r_acc;
      w_quo  = (r_neg_a ^ r_neg_b) ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
      w_rem  = r_neg_a ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
      case (r_op)
         OP_MUL:                        w_fix_res = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               w_fix_res = w_quo;
         OP_REM, OP_REMU:               w_fix_res = w_rem;
         default:                       w_fix_res = ZERO;
      endcase
   end

   assign w_is_div_r = is_div(r_op);
   assign w_chain[0] = r_acc;

   for (genvar g = 0; g < UNROLL; g++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
         .i_is_div (w_is_div_r),
         .i_acc    (w_chain[g]),
         .i_opnd   (r_opnd),
         .o_acc    (w_chain[g+1])
      );
   end

   // Control FSM with operand capture, iteration counter and result register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_op        <= OP_MUL;
         r_neg_a     <= 1'b0;
         r_neg_b     <= 1'b0;
         r_opnd      <= ZERO;
         r_acc       <= {(2*XLEN){1'b0}};
         r_cnt       <= {CW{1'b0}};
         r_result    <= ZERO;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // A flush in IDLE blocks a simultaneous request
               if (in_valid && !flush) begin
                  r_op    <= w_op;
                  r_neg_a <= w_neg_a;
                  r_neg_b <= w_neg_b;
                  r_opnd  <= w_mag_b;
                  r_cnt   <= {CW{1'b0}};
                  if (w_special) begin
                     r_acc       <= {(2*XLEN){1'b0}};
                     r_result    <= w_spec_res;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_acc   <= {ZERO, w_mag_a};
                     r_state <= CALC;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            CALC: begin
               if (flush) begin
                  r_state <= IDLE;
               end else begin
                  r_acc <= w_chain[UNROLL];
                  r_cnt <= r_cnt + CNT_ONE;
                  if (r_cnt == CNT_LAST) begin
                     r_state <= FIX;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            FIX: begin
               if (flush) begin
                  r_state <= IDLE;
               end else begin
                  r_result    <= w_fix_res;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               // flush wins over out_ready; both return to IDLE without a result
               if (flush || out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end else begin
                  r_state <= DONE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit in two
// configurations (XLEN=32/UNROLL=1 and XLEN=64/UNROLL=4) against a
// wide-arithmetic reference model.
module tb_muldiv_unit;

   logic        clk;
   logic        reset;

   logic        iv32, ir32, fl32, ov32, or32;
   logic [2:0]  op32;
   logic [31:0] a32, b32, res32;

   logic        iv64, ir64, fl64, ov64, or64;
   logic [2:0]  op64;
   logic [63:0] a64, b64, res64;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_unit #(.XLEN(32), .UNROLL(1)) u_dut32 (
      .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .op(op32),
      .a(a32), .b(b32), .flush(fl32), .out_valid(ov32), .out_ready(or32),
      .result(res32)
   );

   muldiv_unit #(.XLEN(64), .UNROLL(4)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .op(op64),
      .a(a64), .b(b64), .flush(fl64), .out_valid(ov64), .out_ready(or64),
      .result(res64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: exact products from sign/zero-extended 128-bit values,
   // native signed/unsigned division with the RISC-V corner cases.
   function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] ia,
                                             input logic [63:0] ib, input int w);
      logic [63:0]  mask, ua, ub, mn, res;
      logic [127:0] ea, eb, prod;
      longint       sa, sb;
      logic         sgn_a, sgn_b, ovf;
      mask  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      mn    = (w == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      ua    = ia & mask;
      ub    = ib & mask;
      sgn_a = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
      sgn_b = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      if (w == 32) begin
         sa = longint'($signed(ua[31:0]));
         sb = longint'($signed(ub[31:0]));
      end else begin
         sa = $signed(ua);
         sb = $signed(ub);
      end
      ea   = sgn_a ? {{64{sa[63]}}, sa} : {64'd0, ua};
      eb   = sgn_b ? {{64{sb[63]}}, sb} : {64'd0, ub};
      prod = ea * eb;
      ovf  = (ua == mn) && (ub == mask);
      case (op)
         3'd0:             res = prod[63:0];
         3'd1, 3'd2, 3'd3: res = (w == 32) ? {32'd0, prod[63:32]} : prod[127:64];
         3'd4:             res = (ub == 64'd0) ? mask : (ovf ? ua : 64'(sa / sb));
         3'd5:             res = (ub == 64'd0) ? mask : (ua / ub);
         3'd6:             res = (ub == 64'd0) ? ua : (ovf ? 64'd0 : 64'(sa % sb));
         default:          res = (ub == 64'd0) ? ua : (ua % ub);
      endcase
      return res & mask;
   endfunction

   // Expected edges from accept (counted as edge 1) to out_valid
   function automatic int exp_lat(input logic [2:0] op, input logic [63:0] ia,
                                  input logic [63:0] ib, input int w, input int n);
      logic [63:0] mask, mn;
      logic        special;
      mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      mn   = (w == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      special = (op >= 3'd4) && (((ib & mask) == 64'd0) ||
                ((op == 3'd4 || op == 3'd6) && ((ia & mask) == mn) && ((ib & mask) == mask)));
      return special ? 1 : n + 2;
   endfunction

   function automatic logic [63:0] pick_opnd(input int w);
      logic [63:0] v;
      int sel = $urandom_range(0, 9);
      case (sel)
         0:       v = 64'd0;
         1:       v = 64'd1;
         2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
         3:       v = (w == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
         4:       v = 64'($urandom_range(0, 15));
         default: v = {$urandom, $urandom};
      endcase
      if (w == 32) v = {32'd0, v[31:0]};
      return v;
   endfunction

   function automatic logic get_ov(input bit wide);
      return wide ? ov64 : ov32;
   endfunction

   function automatic logic get_ir(input bit wide);
      return wide ? ir64 : ir32;
   endfunction

   function automatic logic [63:0] get_res(input bit wide);
      return wide ? res64 : {32'd0, res32};
   endfunction

   task automatic drive_req(input bit wide, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      if (wide) begin
         iv64 = 1'b1; op64 = op; a64 = a; b64 = b;
      end else begin
         iv32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0];
      end
   endtask

   // Drop the request and scramble the operand inputs after accept
   task automatic clear_req(input bit wide);
      if (wide) begin
         iv64 = 1'b0; op64 = 3'($urandom_range(0, 7)); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      end else begin
         iv32 = 1'b0; op32 = 3'($urandom_range(0, 7)); a32 = $urandom; b32 = $urandom;
      end
   endtask

   // Called #1 after the accept edge; counts edges until out_valid
   task automatic wait_done(input bit wide, output logic [63:0] res, output int lat, output bit rdy_low);
      lat = 1;
      rdy_low = 1'b1;
      while (!get_ov(wide) && lat < 100) begin
         if (get_ir(wide)) rdy_low = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (get_ir(wide)) rdy_low = 1'b0;
      res = get_res(wide);
   endtask

   task automatic run_op(input bit wide, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat, output bit rdy_low);
      drive_req(wide, op, a, b);
      @(posedge clk); #1;
      clear_req(wide);
      wait_done(wide, res, lat, rdy_low);
   endtask

   task automatic ack(input bit wide);
      @(negedge clk);
      if (wide) or64 = 1'b1; else or32 = 1'b1;
      @(posedge clk); #1;
      if (wide) or64 = 1'b0; else or32 = 1'b0;
   endtask

   task automatic run_check(input string tag, input bit wide, input logic [2:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] exp, input int elat);
      logic [63:0] res;
      int          lat;
      bit          rl;
      run_op(wide, op, a, b, res, lat, rl);
      check_val({tag, " result"}, res, exp);
      check_val({tag, " latency"}, 64'(lat), 64'(elat));
      check_val({tag, " in_ready_low"}, 64'(rl), 64'd1);
      ack(wide);
   endtask

   initial begin
      logic [63:0] res, ra, rb;
      logic [2:0]  rop;
      int          lat;
      bit          rl, seen;

      reset = 1'b0;
      iv32 = 1'b0; fl32 = 1'b0; or32 = 1'b0; op32 = 3'd0; a32 = 32'd0; b32 = 32'd0;
      iv64 = 1'b0; fl64 = 1'b0; or64 = 1'b0; op64 = 3'd0; a64 = 64'd0; b64 = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst in_ready32", 64'(ir32), 64'd1);
      check_val("rst out_valid32", 64'(ov32), 64'd0);
      check_val("rst result32", {32'd0, res32}, 64'd0);
      check_val("rst out_valid64", 64'(ov64), 64'd0);
      check_val("rst result64", res64, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed XLEN=32, UNROLL=1
      run_check("mul",       1'b0, 3'd0, 64'd7,           64'hFFFF_FFFD, 64'hFFFF_FFEB, 34);
      run_check("mulhu",     1'b0, 3'd3, 64'hFFFF_FFFF,   64'hFFFF_FFFF, 64'hFFFF_FFFE, 34);
      run_check("mulh",      1'b0, 3'd1, 64'h8000_0000,   64'h8000_0000, 64'h4000_0000, 34);
      run_check("mulhsu",    1'b0, 3'd2, 64'hFFFF_FFFF,   64'd2,         64'hFFFF_FFFF, 34);
      run_check("div",       1'b0, 3'd4, 64'hFFFF_FFF9,   64'd2,         64'hFFFF_FFFD, 34);
      run_check("rem",       1'b0, 3'd6, 64'hFFFF_FFF9,   64'd2,         64'hFFFF_FFFF, 34);
      run_check("divu",      1'b0, 3'd5, 64'd100,         64'd7,         64'd14,        34);
      run_check("remu",      1'b0, 3'd7, 64'd100,         64'd7,         64'd2,         34);
      run_check("divu_by0",  1'b0, 3'd5, 64'd5,           64'd0,         64'hFFFF_FFFF, 1);
      run_check("remu_by0",  1'b0, 3'd7, 64'd5,           64'd0,         64'd5,         1);
      run_check("div_ovf",   1'b0, 3'd4, 64'h8000_0000,   64'hFFFF_FFFF, 64'h8000_0000, 1);
      run_check("rem_ovf",   1'b0, 3'd6, 64'h8000_0000,   64'hFFFF_FFFF, 64'd0,         1);

      // Backpressure with a pending request held on the input
      run_op(1'b0, 3'd0, 64'd6, 64'd7, res, lat, rl);
      check_val("bp first result", res, 64'd42);
      @(negedge clk);
      iv32 = 1'b1; op32 = 3'd3; a32 = 32'hFFFF_FFFF; b32 = 32'd2;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_val("bp hold result", {32'd0, res32}, 64'd42);
         check_val("bp hold out_valid", 64'(ov32), 64'd1);
         check_val("bp hold in_ready", 64'(ir32), 64'd0);
      end
      @(negedge clk);
      or32 = 1'b1;
      @(posedge clk); #1;
      or32 = 1'b0;
      check_val("bp release in_ready", 64'(ir32), 64'd1);
      check_val("bp release out_valid", 64'(ov32), 64'd0);
      @(posedge clk); #1;
      check_val("bp next accepted", 64'(ir32), 64'd0);
      clear_req(1'b0);
      wait_done(1'b0, res, lat, rl);
      check_val("bp next result", res, 64'd1);
      check_val("bp next latency", 64'(lat), 64'd34);
      ack(1'b0);

      // Flush during CALC cycle 10
      drive_req(1'b0, 3'd0, 64'h1234, 64'h5678);
      @(posedge clk); #1;
      clear_req(1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      fl32 = 1'b1;
      @(posedge clk); #1;
      fl32 = 1'b0;
      check_val("flush calc in_ready", 64'(ir32), 64'd1);
      check_val("flush calc out_valid", 64'(ov32), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ov32) seen = 1'b1;
      end
      check_val("flush no out_valid", 64'(seen), 64'd0);
      run_check("after flush mul", 1'b0, 3'd0, 64'd3, 64'd4, 64'd12, 34);

      // Flush from DONE drops the result handshake
      run_op(1'b0, 3'd5, 64'd100, 64'd9, res, lat, rl);
      check_val("flush done result", res, 64'd11);
      @(negedge clk);
      fl32 = 1'b1;
      @(posedge clk); #1;
      fl32 = 1'b0;
      check_val("flush done out_valid", 64'(ov32), 64'd0);
      check_val("flush done in_ready", 64'(ir32), 64'd1);

      // Flush in IDLE blocks a simultaneous request
      @(negedge clk);
      iv32 = 1'b1; op32 = 3'd0; a32 = 32'd5; b32 = 32'd5; fl32 = 1'b1;
      @(posedge clk); #1;
      iv32 = 1'b0; fl32 = 1'b0;
      check_val("flush idle no accept", 64'(ir32), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check_val("flush idle out_valid", 64'(ov32), 64'd0);

      // Reset in the middle of CALC
      drive_req(1'b0, 3'd5, 64'd1000, 64'd3);
      @(posedge clk); #1;
      clear_req(1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check_val("mid reset in_ready", 64'(ir32), 64'd1);
      check_val("mid reset out_valid", 64'(ov32), 64'd0);
      check_val("mid reset result", {32'd0, res32}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      run_check("after reset divu", 1'b0, 3'd5, 64'd1000, 64'd3, 64'd333, 34);

      // Random XLEN=32
      for (int i = 0; i < 200; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = pick_opnd(32);
         rb  = pick_opnd(32);
         run_check($sformatf("rnd32 op=%0d a=%0h b=%0h", rop, ra, rb), 1'b0, rop, ra, rb,
                   ref_model(rop, ra, rb, 32), exp_lat(rop, ra, rb, 32, 32));
      end

      // Directed and random XLEN=64, UNROLL=4
      run_check("mul64",   1'b1, 3'd0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 18);
      run_check("mulhu64", 1'b1, 3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 18);
      for (int i = 0; i < 1000; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = pick_opnd(64);
         rb  = pick_opnd(64);
         run_check($sformatf("rnd64 op=%0d a=%0h b=%0h", rop, ra, rb), 1'b1, rop, ra, rb,
                   ref_model(rop, ra, rb, 64), exp_lat(rop, ra, rb, 64, 16));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
